// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Requests are granted round-robin and each accepted operation's result is
// captured in a one-deep registered response slot with its own valid/ready
// handshake. An accepted operation appears on rsp_* one cycle later, and a
// new operation can be accepted every cycle while the consumer drains the slot.
//
// Optional feature macro: ALU_ARB_PERF_EN
//   When defined, adds saturating per-port transfer counters grant0_cnt/grant1_cnt.
//   When it is not defined, those ports and counters do not exist.
//
// Parameters:
//   WIDTH      operand/result width
//   RESET_PRIO requester that wins the first tie after reset (0 or 1)
//   CNT_W      width of the optional grant counters
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   req0_valid/ready/ctrl/a/b requester 0 handshake, ALU control code, operands
//   req1_valid/ready/ctrl/a/b requester 1 handshake, ALU control code, operands
//   rsp_valid/ready           response slot handshake
//   rsp_id                    requester that issued the held result
//   rsp_result                held ALU result
//   rsp_zero                  held result is zero
//   rsp_illegal               held operation used an undefined ctrl code
//   grant0_cnt/grant1_cnt     transfer counters (only with ALU_ARB_PERF_EN)

module alu_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RESET_PRIO = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    // Elaboration-time parameter sanity checks.
    if (RESET_PRIO > 1) begin : g_bad_reset_prio
        $error("alu_arbiter: RESET_PRIO must be 0 or 1");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("alu_arbiter: CNT_W must be at least 1");
    end

    // Registered state.
    logic             r_prio;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_illegal;

    // Combinational arbitration and datapath.
    logic             w_slot_free;
    logic             w_grant_vld;
    logic             w_grant_id;
    logic             w_xfer;
    logic [2:0]       w_ctrl;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_illegal;

    // The slot can take a new result when empty or being drained this cycle.
    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // Grant selection: a lone requester wins; a tie goes to the priority pointer.
    // Depends only on the valids, never on the other port's ready.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = r_prio;
        end else if (req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b0;
        end else if (req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
        end
    end

    assign req0_ready = w_slot_free && w_grant_vld && !w_grant_id;
    assign req1_ready = w_slot_free && w_grant_vld &&  w_grant_id;
    assign w_xfer     = w_slot_free && w_grant_vld;

    // Operand mux for the granted requester.
    always_comb begin
        w_ctrl = req0_ctrl;
        w_a    = req0_a;
        w_b    = req0_b;
        if (w_grant_id) begin
            w_ctrl = req1_ctrl;
            w_a    = req1_a;
            w_b    = req1_b;
        end
    end

    // Shared ALU; undefined codes yield a zero result flagged as illegal.
    always_comb begin
        w_alu_result  = '0;
        w_alu_illegal = 1'b0;
        case (w_ctrl)
            OP_ADD:  w_alu_result = w_a + w_b;
            OP_SUB:  w_alu_result = w_a - w_b;
            OP_AND:  w_alu_result = w_a & w_b;
            OP_OR:   w_alu_result = w_a | w_b;
            OP_SLT:  w_alu_result = WIDTH'(w_a < w_b);
            default: begin
                w_alu_result  = '0;
                w_alu_illegal = 1'b1;
            end
        endcase
    end

    // Response slot and round-robin pointer. A drain without a new transfer
    // only clears valid; the payload fields keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio        <= 1'(RESET_PRIO);
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_prio        <= !w_grant_id;
                r_rsp_valid   <= 1'b1;
                r_rsp_id      <= w_grant_id;
                r_rsp_result  <= w_alu_result;
                r_rsp_zero    <= (w_alu_result == '0);
                r_rsp_illegal <= w_alu_illegal;
            end else if (rsp_ready) begin
                r_rsp_valid   <= 1'b0;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] r_grant0_cnt;
    logic [CNT_W-1:0] r_grant1_cnt;

    // Saturating per-port transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
        end else begin
            if (req0_valid && req0_ready && (r_grant0_cnt != '1)) begin
                r_grant0_cnt <= r_grant0_cnt + CNT_W'(1);
            end
            if (req1_valid && req1_ready && (r_grant1_cnt != '1)) begin
                r_grant1_cnt <= r_grant1_cnt + CNT_W'(1);
            end
        end
    end

    assign grant0_cnt = r_grant0_cnt;
    assign grant1_cnt = r_grant1_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
// Inputs change and outputs are sampled around the falling clock edge.

module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 2;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] SLT = 3'b101;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_ctrl;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_ctrl;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_illegal;
`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] grant0_cnt;
    logic [CNT_W-1:0] grant1_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_arbiter #(
        .WIDTH      (WIDTH),
        .RESET_PRIO (0),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_ctrl   (req0_ctrl),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_ctrl   (req1_ctrl),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal)
`ifdef ALU_ARB_PERF_EN
        ,
        .grant0_cnt  (grant0_cnt),
        .grant1_cnt  (grant1_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v;
        req0_ctrl  = c;
        req0_a     = a;
        req0_b     = b;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v;
        req1_ctrl  = c;
        req1_a     = a;
        req1_b     = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_req0(1'b0, ADD, 0, 0);
        set_req1(1'b0, ADD, 0, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ALU vector table driven through requester 0.
    logic [2:0]  v_ctrl [8] = '{ADD, SUB, AND, OR, SLT, SLT, 3'b100, 3'b111};
    logic [31:0] v_a    [8] = '{32'hFFFF_FFFF, 32'd10, 32'hF0F0_F0F0, 32'h0F0F_0000,
                                32'd5, 32'h8000_0000, 32'd7, 32'd1};
    logic [31:0] v_b    [8] = '{32'd1, 32'd3, 32'hFF00_FF00, 32'h0000_F0F0,
                                32'd3, 32'h8000_0001, 32'd7, 32'd2};
    logic [31:0] v_res  [8] = '{32'd0, 32'd7, 32'hF000_F000, 32'h0F0F_F0F0,
                                32'd0, 32'd1, 32'd0, 32'd0};
    logic        v_ill  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_req0(1'b0, ADD, 0, 0);
        set_req1(1'b0, ADD, 0, 0);

        // Reset state.
        @(negedge clk);
        chk("rst_valid",   32'(rsp_valid),   32'd0);
        chk("rst_id",      32'(rsp_id),      32'd0);
        chk("rst_result",  rsp_result,       32'd0);
        chk("rst_zero",    32'(rsp_zero),    32'd0);
        chk("rst_illegal", 32'(rsp_illegal), 32'd0);
        chk("rst_rdy0",    32'(req0_ready),  32'd0);
        chk("rst_rdy1",    32'(req1_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add on port 0: ready same cycle, result next cycle.
        @(negedge clk);
        set_req0(1'b1, ADD, 5, 7);
        #1;
        chk("t1_rdy0", 32'(req0_ready), 32'd1);
        chk("t1_rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        set_req0(1'b0, ADD, 0, 0);
        chk("t1_valid",  32'(rsp_valid), 32'd1);
        chk("t1_id",     32'(rsp_id),    32'd0);
        chk("t1_result", rsp_result,     32'd12);
        chk("t1_zero",   32'(rsp_zero),  32'd0);

        // Continuous dual requests alternate grants starting at port 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_req0(1'b1, ADD, 32'(10 + i), 1);
            set_req1(1'b1, OR, 32'(i), 32'h100);
            if (i > 0) begin
                chk("rr_id", 32'(rsp_id), 32'((i - 1) % 2));
                chk("rr_result", rsp_result,
                    ((i - 1) % 2 == 0) ? 32'(11 + i - 1) : (32'h100 | 32'(i - 1)));
            end
            #1;
            chk("rr_rdy0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("rr_rdy1", 32'(req1_ready), 32'(i % 2 == 1));
        end
        @(negedge clk);
        set_req0(1'b0, ADD, 0, 0);
        set_req1(1'b0, ADD, 0, 0);
        chk("rr_last_id", 32'(rsp_id), 32'd1);
        chk("rr_last_result", rsp_result, 32'h103);

        // Drain without transfer keeps payload; then load 0-1 and stall.
        @(negedge clk);
        chk("drain_valid",  32'(rsp_valid), 32'd0);
        chk("drain_id",     32'(rsp_id),    32'd1);
        chk("drain_result", rsp_result,     32'h103);
        set_req0(1'b1, SUB, 0, 1);
        rsp_ready = 1'b0;
        #1;
        chk("sub_rdy0", 32'(req0_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_req0(1'b1, ADD, 1, 1);
                set_req1(1'b1, AND, 32'hFF, 32'h0F);
            end
            #1;
            chk("bp_rdy0",   32'(req0_ready), 32'd0);
            chk("bp_rdy1",   32'(req1_ready), 32'd0);
            chk("bp_valid",  32'(rsp_valid),  32'd1);
            chk("bp_result", rsp_result,      32'hFFFF_FFFF);
            chk("bp_id",     32'(rsp_id),     32'd0);
            chk("bp_zero",   32'(rsp_zero),   32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_rdy1", 32'(req1_ready), 32'd1);
        chk("bp_rel_rdy0", 32'(req0_ready), 32'd0);

        // SLT with unsigned compare, then an illegal code from port 1.
        @(negedge clk);
        chk("bp_out_id",     32'(rsp_id), 32'd1);
        chk("bp_out_result", rsp_result,  32'h0F);
        set_req1(1'b0, ADD, 0, 0);
        set_req0(1'b1, SLT, 3, 32'hFFFF_FFFF);
        #1;
        chk("slt_rdy0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        chk("slt_result",  rsp_result,       32'd1);
        chk("slt_id",      32'(rsp_id),      32'd0);
        chk("slt_illegal", 32'(rsp_illegal), 32'd0);
        chk("slt_zero",    32'(rsp_zero),    32'd0);
        set_req0(1'b0, ADD, 0, 0);
        set_req1(1'b1, 3'b110, 5, 6);
        #1;
        chk("ill_rdy1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        set_req1(1'b0, ADD, 0, 0);
        chk("ill_result",  rsp_result,       32'd0);
        chk("ill_zero",    32'(rsp_zero),    32'd1);
        chk("ill_illegal", 32'(rsp_illegal), 32'd1);
        chk("ill_id",      32'(rsp_id),      32'd1);

        // Back-to-back ALU vectors on port 0.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_req0(1'b1, v_ctrl[i], v_a[i], v_b[i]);
            if (i > 0) begin
                chk("vec_result",  rsp_result,       v_res[i-1]);
                chk("vec_illegal", 32'(rsp_illegal), 32'(v_ill[i-1]));
                chk("vec_zero",    32'(rsp_zero),    32'(v_res[i-1] == 32'd0));
            end
        end
        @(negedge clk);
        set_req0(1'b0, ADD, 0, 0);
        chk("vec_result",  rsp_result,       v_res[7]);
        chk("vec_illegal", 32'(rsp_illegal), 32'(v_ill[7]));

        // Asynchronous reset mid-cycle with a held response; pointer was at 1.
        @(negedge clk);
        set_req0(1'b1, ADD, 2, 2);
        rsp_ready = 1'b0;
        @(negedge clk);
        set_req0(1'b0, ADD, 0, 0);
        chk("ar_pre_valid",  32'(rsp_valid), 32'd1);
        chk("ar_pre_result", rsp_result,     32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",  32'(rsp_valid), 32'd0);
        chk("ar_result", rsp_result,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        set_req0(1'b1, OR, 1, 2);
        set_req1(1'b1, OR, 3, 4);
        #1;
        chk("ar_tie_rdy0", 32'(req0_ready), 32'd1);
        chk("ar_tie_rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        set_req0(1'b0, ADD, 0, 0);
        set_req1(1'b0, ADD, 0, 0);
        chk("ar_tie_result", rsp_result, 32'd3);

`ifdef ALU_ARB_PERF_EN
        // Counter saturation with CNT_W=2.
        do_reset();
        chk("cnt0_rst", 32'(grant0_cnt), 32'd0);
        chk("cnt1_rst", 32'(grant1_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_req0(1'b1, ADD, 32'(i), 1);
        end
        @(negedge clk);
        set_req0(1'b0, ADD, 0, 0);
        chk("cnt0_sat", 32'(grant0_cnt), 32'd3);
        chk("cnt1_sat", 32'(grant1_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
